// File: rtl/sysid_check_ctrl.sv
// sysid_check_ctrl: boot-time system-ID verifier.
// Acts as an Avalon-MM read master toward the sysid control slave. It fetches
// the ID word (address 0) and the timestamp word (address 1), compares both
// against the build-time constants, and reports pass/fail/timeout to the
// reset supervisor. All outputs are registered.

module sysid_check_ctrl #(
    parameter logic [31:0] EXPECTED_ID  = 32'h0000_0000,
    parameter logic [31:0] EXPECTED_TS  = 32'h5E45_07BF,
    parameter int unsigned READ_LATENCY = 32'd0,
    parameter int unsigned TIMEOUT      = 32'd255,
    parameter bit          AUTO_START   = 1'b1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    output logic        avm_address,
    output logic        avm_read,
    input  logic        avm_waitrequest,
    input  logic [31:0] avm_readdata,
    output logic        busy,
    output logic        done,
    output logic        id_ok,
    output logic        ts_ok,
    output logic [31:0] id_value,
    output logic [31:0] ts_value,
    output logic        timeout_err
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        RD_ID  = 3'd1,
        LAT_ID = 3'd2,
        RD_TS  = 3'd3,
        LAT_TS = 3'd4,
        FIN    = 3'd5,
        ERR    = 3'd6
    } state_t;

    // Zero-latency slaves return data in the accept cycle, so the latency
    // states are skipped entirely in that configuration.
    localparam bit          LAT_ZERO     = (READ_LATENCY == 32'd0);
    // Last latency count; unreachable (and harmless) when LAT_ZERO is set.
    localparam logic [2:0]  LAT_LAST     = 3'(READ_LATENCY - 32'd1);
    // Stall count at which one more stalled cycle means the budget is spent.
    localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT - 32'd1);

    state_t      state_r, state_s;
    logic        read_r, read_s;
    logic        address_r, address_s;
    logic        busy_r, busy_s;
    logic        done_r, done_s;
    logic        id_ok_r, id_ok_s;
    logic        ts_ok_r, ts_ok_s;
    logic [31:0] id_value_r, id_value_s;
    logic [31:0] ts_value_r, ts_value_s;
    logic        timeout_err_r, timeout_err_s;
    logic [15:0] wait_cnt_r, wait_cnt_s;
    logic [2:0]  lat_cnt_r, lat_cnt_s;
    logic        auto_pend_r;

    // State, counters and every registered output; reset returns all to zero.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r       <= IDLE;
            read_r        <= 1'b0;
            address_r     <= 1'b0;
            busy_r        <= 1'b0;
            done_r        <= 1'b0;
            id_ok_r       <= 1'b0;
            ts_ok_r       <= 1'b0;
            id_value_r    <= 32'h0000_0000;
            ts_value_r    <= 32'h0000_0000;
            timeout_err_r <= 1'b0;
            wait_cnt_r    <= 16'd0;
            lat_cnt_r     <= 3'd0;
            auto_pend_r   <= AUTO_START;
        end else begin
            state_r       <= state_s;
            read_r        <= read_s;
            address_r     <= address_s;
            busy_r        <= busy_s;
            done_r        <= done_s;
            id_ok_r       <= id_ok_s;
            ts_ok_r       <= ts_ok_s;
            id_value_r    <= id_value_s;
            ts_value_r    <= ts_value_s;
            timeout_err_r <= timeout_err_s;
            wait_cnt_r    <= wait_cnt_s;
            lat_cnt_r     <= lat_cnt_s;
            // Auto launch is only honoured on the first cycle after reset.
            auto_pend_r   <= 1'b0;
        end
    end

    // Next-state logic and next values of the registered outputs.
    always_comb begin
        state_s       = state_r;
        read_s        = read_r;
        address_s     = address_r;
        busy_s        = busy_r;
        done_s        = 1'b0;
        id_ok_s       = id_ok_r;
        ts_ok_s       = ts_ok_r;
        id_value_s    = id_value_r;
        ts_value_s    = ts_value_r;
        timeout_err_s = timeout_err_r;
        wait_cnt_s    = wait_cnt_r;
        lat_cnt_s     = lat_cnt_r;

        case (state_r)
            IDLE: begin
                if (start || auto_pend_r) begin
                    state_s       = RD_ID;
                    read_s        = 1'b1;
                    address_s     = 1'b0;
                    busy_s        = 1'b1;
                    id_ok_s       = 1'b0;
                    ts_ok_s       = 1'b0;
                    timeout_err_s = 1'b0;
                    wait_cnt_s    = 16'd0;
                    lat_cnt_s     = 3'd0;
                end else begin
                    read_s = 1'b0;
                    busy_s = 1'b0;
                end
            end

            RD_ID: begin
                if (avm_waitrequest) begin
                    // Address and read are held; only the stall budget moves.
                    wait_cnt_s = wait_cnt_r + 16'd1;
                    if (wait_cnt_r == TIMEOUT_LAST) begin
                        state_s = ERR;
                        read_s  = 1'b0;
                    end else begin
                        state_s = RD_ID;
                    end
                end else if (LAT_ZERO) begin
                    // Data is valid in the accept cycle; chain straight into
                    // the timestamp read with the new address in the same cycle.
                    id_value_s = avm_readdata;
                    state_s    = RD_TS;
                    read_s     = 1'b1;
                    address_s  = 1'b1;
                    wait_cnt_s = 16'd0;
                end else begin
                    state_s   = LAT_ID;
                    read_s    = 1'b0;
                    lat_cnt_s = 3'd0;
                end
            end

            LAT_ID: begin
                if (lat_cnt_r == LAT_LAST) begin
                    id_value_s = avm_readdata;
                    state_s    = RD_TS;
                    read_s     = 1'b1;
                    address_s  = 1'b1;
                    wait_cnt_s = 16'd0;
                end else begin
                    lat_cnt_s = lat_cnt_r + 3'd1;
                end
            end

            RD_TS: begin
                if (avm_waitrequest) begin
                    wait_cnt_s = wait_cnt_r + 16'd1;
                    if (wait_cnt_r == TIMEOUT_LAST) begin
                        state_s = ERR;
                        read_s  = 1'b0;
                    end else begin
                        state_s = RD_TS;
                    end
                end else if (LAT_ZERO) begin
                    ts_value_s = avm_readdata;
                    state_s    = FIN;
                    read_s     = 1'b0;
                end else begin
                    state_s   = LAT_TS;
                    read_s    = 1'b0;
                    lat_cnt_s = 3'd0;
                end
            end

            LAT_TS: begin
                if (lat_cnt_r == LAT_LAST) begin
                    ts_value_s = avm_readdata;
                    state_s    = FIN;
                end else begin
                    lat_cnt_s = lat_cnt_r + 3'd1;
                end
            end

            FIN: begin
                // Compare against the already-registered captures so the
                // comparators never sit on the slave's read-data path.
                id_ok_s = (id_value_r == EXPECTED_ID);
                ts_ok_s = (ts_value_r == EXPECTED_TS);
                done_s  = 1'b1;
                busy_s  = 1'b0;
                read_s  = 1'b0;
                state_s = IDLE;
            end

            ERR: begin
                timeout_err_s = 1'b1;
                id_ok_s       = 1'b0;
                ts_ok_s       = 1'b0;
                done_s        = 1'b1;
                busy_s        = 1'b0;
                read_s        = 1'b0;
                state_s       = IDLE;
            end

            default: begin
                state_s = IDLE;
                read_s  = 1'b0;
                busy_s  = 1'b0;
            end
        endcase
    end

    assign avm_address = address_r;
    assign avm_read    = read_r;
    assign busy        = busy_r;
    assign done        = done_r;
    assign id_ok       = id_ok_r;
    assign ts_ok       = ts_ok_r;
    assign id_value    = id_value_r;
    assign ts_value    = ts_value_r;
    assign timeout_err = timeout_err_r;

    sysid_check_ctrl_chk u_chk (
        .clock           (clock),
        .reset           (reset),
        .avm_read        (avm_read),
        .avm_address     (avm_address),
        .avm_waitrequest (avm_waitrequest),
        .busy            (busy),
        .done            (done)
    );

endmodule

// Protocol invariants of the sequencer's Avalon-MM master and status outputs.
module sysid_check_ctrl_chk (
    input logic clock,
    input logic reset,
    input logic avm_read,
    input logic avm_address,
    input logic avm_waitrequest,
    input logic busy,
    input logic done
);

    // done is a single-cycle pulse.
    a_done_pulse: assert property (@(posedge clock) disable iff (reset)
        done |=> !done);

    // Address must not move while the slave is stalling a read.
    a_addr_stable: assert property (@(posedge clock) disable iff (reset)
        (avm_read && avm_waitrequest) |=> (avm_address == $past(avm_address)));

    // No bus activity outside a check.
    a_idle_quiet: assert property (@(posedge clock) disable iff (reset)
        !busy |-> !avm_read);

    // Completion and busy are mutually exclusive.
    a_done_not_busy: assert property (@(posedge clock) disable iff (reset)
        done |-> !busy);

endmodule

// File: doc/sysid_check_ctrl.md
Name: sysid_check_ctrl

Overview:
Avalon-MM master sequencer that reads the system-ID slave at boot or on request. It fetches the ID word (address 0) and the timestamp word (address 1), then compares both against the values expected by the software build. It reports match/mismatch and timeout status to the boot/reset supervisor. It sits between the supervisor and the sysid control_slave on the same clock domain.

Parameters:
EXPECTED_ID, 32'h0000_0000, ID word the build expects at address 0
EXPECTED_TS, 32'h5E45_07BF, timestamp word the build expects at address 1
READ_LATENCY, 0, fixed slave read latency in cycles (0..7) after waitrequest deasserts
TIMEOUT, 255, maximum consecutive waitrequest-high cycles per read (1..65535)
AUTO_START, 1, 1 = launch one check automatically on the first cycle after reset release

Ports:
clock  in  1  system clock, all logic rising-edge
reset  in  1  synchronous, active-high reset
start  in  1  single-cycle request to run a check; ignored while busy
avm_address  out  1  slave word address (0 = ID, 1 = timestamp)
avm_read  out  1  read strobe
avm_waitrequest  in  1  slave stall
avm_readdata  in  32  slave read data
busy  out  1  high from launch until done/error
done  out  1  one-cycle pulse when a check completes (pass or fail)
id_ok  out  1  ID matched on last completed check
ts_ok  out  1  timestamp matched on last completed check
id_value  out  32  captured ID word
ts_value  out  32  captured timestamp word
timeout_err  out  1  sticky: last check aborted on timeout

Behaviour:
- Reset values: avm_address=0, avm_read=0, busy=0, done=0, id_ok=0, ts_ok=0, id_value=0, ts_value=0, timeout_err=0. FSM returns to IDLE. Wait and latency counters clear.
- FSM states: IDLE, RD_ID, LAT_ID, RD_TS, LAT_TS, FIN, ERR.
- IDLE: the FSM launches on start=1, or on the first post-reset cycle if AUTO_START=1. Launch clears id_ok, ts_ok and timeout_err, sets busy=1, and goes to RD_ID.
- RD_ID:
  - Drive avm_read=1 and avm_address=0.
  - Hold address and read stable while avm_waitrequest=1.
  - On the cycle waitrequest=0:
    - READ_LATENCY=0: capture avm_readdata into id_value and go to RD_TS.
    - Otherwise: drop avm_read and go to LAT_ID.
- LAT_ID: count READ_LATENCY cycles. Capture avm_readdata on the final count, then go to RD_TS.
- RD_TS / LAT_TS: identical to RD_ID / LAT_ID with avm_address=1; the captured word goes to ts_value. Next state is FIN.
- Address timing: avm_read is never asserted back-to-back across the ID/TS boundary with a stale address. The address changes in the same cycle as the new read.
- FIN:
  - Registered compares: id_ok = (id_value==EXPECTED_ID), ts_ok = (ts_value==EXPECTED_TS).
  - done=1 for exactly one cycle, busy=0, return to IDLE.
  - Results hold until the next launch.
- Timeout: the wait counter (16 bit) counts cycles with avm_read=1 and waitrequest=1. It resets on each new read phase.
- ERR:
  - Entered when the wait count reaches TIMEOUT while still stalled.
  - avm_read drops that cycle. timeout_err=1, id_ok=ts_ok=0, done pulses once, busy=0, then IDLE.
- Latency: with READ_LATENCY=0 and no stalls, busy lasts 3 cycles (RD_ID, RD_TS, FIN). done asserts 3 cycles after launch.
- start while busy: ignored, no queuing.
- start in the same cycle as done: accepted next cycle (FSM is in IDLE).
- reset mid-read: avm_read deasserts the cycle after reset is sampled; all outputs return to reset values; no partial results are retained.
- Capture is 32-bit verbatim, with no masking.

Test Plan:
- Boot: AUTO_START=1, slave returns 0 / 32'h5E45_07BF, no stalls -> done pulse at cycle 3, id_ok=1, ts_ok=1, ts_value=32'h5E45_07BF, timeout_err=0.
- Timestamp mismatch: slave addr1 returns 32'h5E45_07C0, start pulse -> done, id_ok=1, ts_ok=0, ts_value=32'h5E45_07C0.
- Stall: waitrequest held 10 cycles on the ID read -> avm_read and avm_address=0 stable for 11 cycles, completion with correct values, done 13 cycles after start.
- Timeout: TIMEOUT=4, waitrequest stuck high -> avm_read high 4 cycles then low, timeout_err=1, done single pulse, busy=0, no addr1 read issued.
- Latency: READ_LATENCY=2, data valid 2 cycles after accept -> captured values correct, avm_read one cycle per phase, busy 7 cycles.
- Reset/start robustness: reset asserted during RD_TS -> all outputs zero next cycle. A start pulse during busy -> no second check (exactly one done).
